fetch_stage: RTL

Instruction-fetch stage that sits directly upstream of the instruction memory and feeds the decode stage. It owns the program counter and drives the memory's byte address. It captures the combinational 32-bit read word into an IF/ID pipeline register that carries a valid/ready handshake. It also handles stalls, branch/jump redirects, halt, and a retired-fetch counter.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_byte_order.sv | 18 +
 rtl/fetch_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its consumers.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // IF/ID pipeline entry as seen by the decode stage (32-bit PC datapath).
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_byte_order.sv
// Reorders the instruction-memory word into little-endian instruction order.
module fetch_byte_order #(
  parameter bit SWAP_BYTES = 1'b1
) (
  input  logic [31:0] rd,
  output logic [31:0] word
);

  generate
    if (SWAP_BYTES) begin : g_swap
      // Memory returns the lowest-addressed byte in bits [31:24].
      assign word = {rd[7:0], rd[15:8], rd[23:16], rd[31:24]};
    end else begin : g_pass
      assign word = rd;
    end
  endgenerate

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory and holds the IF/ID register with a valid/ready handshake.
module fetch_stage #(
  parameter int                   A_WIDTH    = 32,
  parameter logic [A_WIDTH-1:0]   RESET_PC   = '0,
  parameter bit                   SWAP_BYTES = 1'b1,
  parameter logic [31:0]          NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [A_WIDTH-1:0] redirect_pc,
  input  logic               halt_req,
  input  logic               resume,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [31:0]        id_instr,
  output logic [A_WIDTH-1:0] id_pc,
  output logic [A_WIDTH-1:0] id_pc_plus4,
  output logic               fetch_err,
  output logic [31:0]        fetch_count
);

  localparam logic [1:0] S_BOOT   = 2'(fetch_pkg::BOOT);
  localparam logic [1:0] S_RUN    = 2'(fetch_pkg::RUN);
  localparam logic [1:0] S_HALTED = 2'(fetch_pkg::HALTED);

  logic [1:0]         state_q;
  logic [A_WIDTH-1:0] pc_q;
  logic [A_WIDTH-1:0] pc_next_seq;
  logic [31:0]        word;
  logic               fire;
  logic               can_load;
  logic               redirect_aligned;

  fetch_byte_order #(
    .SWAP_BYTES(SWAP_BYTES)
  ) u_byte_order (
    .rd   (imem_rdata),
    .word (word)
  );

  assign imem_addr        = pc_q;
  assign pc_next_seq      = pc_q + A_WIDTH'(4);
  assign fire             = id_valid & id_ready;
  assign can_load         = !id_valid | id_ready;
  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below sees the pre-edge values of id_valid/pc_q, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      fetch_err   <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (fire) begin
        fetch_count <= fetch_count + 32'd1;
      end

      case (state_q)
        S_BOOT: begin
          state_q <= S_RUN;
        end

        S_RUN: begin
          if (redirect_valid) begin
            // A taken branch flushes the entry even if decode is stalled.
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            if (redirect_aligned) begin
              pc_q <= redirect_pc;
            end else begin
              fetch_err <= 1'b1;
              state_q   <= S_HALTED;
            end
          end else if (halt_req) begin
            state_q <= S_HALTED;
            if (fire) begin
              id_valid <= 1'b0;
            end
          end else if (can_load) begin
            id_instr    <= word;
            id_pc       <= pc_q;
            id_pc_plus4 <= pc_next_seq;
            id_valid    <= 1'b1;
            pc_q        <= pc_next_seq;
          end
        end

        S_HALTED: begin
          if (fire) begin
            id_valid <= 1'b0;
          end
          if (redirect_valid && redirect_aligned) begin
            pc_q <= redirect_pc;
          end
          if (resume && !halt_req) begin
            state_q <= S_RUN;
          end
        end

        default: begin
          state_q <= S_BOOT;
        end
      endcase
    end
  end

endmodule
